// File: rtl/mem_responder.sv
// mem_responder: target side of the core's data-memory read/write handshake.
// Services one request at a time. A read returns READ_NUM consecutive words
// (address wraps modulo 2^ADDR_BITS) in one packed beat; a write stores one
// word. Ready asserts LATENCY cycles after the request is sampled and is held
// until the requester drops valid (4-phase). Storage has a backdoor load port.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   read_valid/read_address         read request (held until read_ready)
//   read_ready/read_data            read response, word i at [i*DATA_BITS +: DATA_BITS]
//   write_valid/write_address/data  write request (held until write_ready)
//   write_ready                     write committed
//   load_en/load_address/load_data  backdoor write, any state (ignored in reset)
module mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned READ_NUM  = 4,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read_valid,
  input  logic [ADDR_BITS-1:0]          read_address,
  output logic                          read_ready,
  output logic [READ_NUM*DATA_BITS-1:0] read_data,
  input  logic                          write_valid,
  input  logic [ADDR_BITS-1:0]          write_address,
  input  logic [DATA_BITS-1:0]          write_data,
  output logic                          write_ready,
  input  logic                          load_en,
  input  logic [ADDR_BITS-1:0]          load_address,
  input  logic [DATA_BITS-1:0]          load_data
);

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_DONE,
    WR_DONE
  } state_t;

  state_t                        state;
  logic [3:0]                    cnt;
  logic [ADDR_BITS-1:0]          rd_addr;
  logic [ADDR_BITS-1:0]          wr_addr;
  logic [DATA_BITS-1:0]          wr_data;
  logic [DATA_BITS-1:0]          mem [DEPTH];
  logic [READ_NUM*DATA_BITS-1:0] rd_word;

  // Gather READ_NUM words from the latched base; the ADDR_BITS-wide sum
  // gives the modulo-2^ADDR_BITS wrap for free.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < READ_NUM; i++) begin
      rd_word[i*DATA_BITS +: DATA_BITS] = mem[rd_addr + ADDR_BITS'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      read_ready  <= 1'b0;
      write_ready <= 1'b0;
      read_data   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Backdoor load precedes the FSM so a same-edge core write commit to
      // the same address overrides it (last nonblocking assignment wins).
      if (load_en) begin
        mem[load_address] <= load_data;
      end

      case (state)
        IDLE: begin
          if (read_valid) begin
            rd_addr <= read_address;
            cnt     <= CNT_INIT;
            state   <= RD_WAIT;
          end else if (write_valid) begin
            wr_addr <= write_address;
            wr_data <= write_data;
            cnt     <= CNT_INIT;
            state   <= WR_WAIT;
          end
        end

        RD_WAIT: begin
          if (!read_valid) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            read_data  <= rd_word;
            read_ready <= 1'b1;
            state      <= RD_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_WAIT: begin
          if (!write_valid) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            mem[wr_addr] <= wr_data;
            write_ready  <= 1'b1;
            state        <= WR_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RD_DONE: begin
          if (!read_valid) begin
            read_ready <= 1'b0;
            state      <= IDLE;
          end
        end

        WR_DONE: begin
          if (!write_valid) begin
            write_ready <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
